// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix reorder family: replay modes,
// ping-pong bank states and a width helper.
package matrix_pkg;

   localparam logic [1:0] MODE_PASS      = 2'd0;
   localparam logic [1:0] MODE_REVERSE   = 2'd1;
   localparam logic [1:0] MODE_TRANSPOSE = 2'd2;
   localparam logic [1:0] MODE_HFLIP     = 2'd3;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FILLING  = 2'd1,
      FULL     = 2'd2,
      DRAINING = 2'd3
   } bank_st_e;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matrix_reorder_stream_if.sv
// Element stream (AXI-Stream subset) carried into and out of the reorder engine.
interface matrix_reorder_stream_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (output tdata, output tvalid, output tlast, input  tready);
   modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/matrix_addr_gen.sv
// Maps an output (row, col) position to the row-major storage address for a
// given replay mode. Purely combinational.
module matrix_addr_gen
   import matrix_pkg::*;
#(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int AW   = 4,
   parameter int CW   = 2
)(
   input  logic [1:0]    mode_i,
   input  logic [CW-1:0] row_i,
   input  logic [CW-1:0] col_i,
   output logic [AW-1:0] addr_o
);
   localparam logic [31:0] NC = 32'(COLS);
   localparam logic [31:0] NL = 32'(ROWS * COLS - 1);

   logic [31:0] r, c, a;

   // For transpose the counters walk the COLSxROWS output, so row is a source column.
   always_comb begin
      r = 32'(row_i);
      c = 32'(col_i);
      case (mode_i)
         MODE_REVERSE:   a = NL - (r * NC + c);
         MODE_TRANSPOSE: a = c * NC + r;
         MODE_HFLIP:     a = r * NC + (NC - 32'd1 - c);
         default:        a = r * NC + c;
      endcase
      addr_o = AW'(a);
   end
endmodule

// File: rtl/matrix_reorder_stream.sv
// Ping-pong matrix reorder engine: fills one bank row-major while the other
// replays in its latched mode through a single output register.
module matrix_reorder_stream
   import matrix_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int DATA_WIDTH = 32
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              mode,
   matrix_reorder_stream_if.slave  in_s,
   matrix_reorder_stream_if.master out_m,
   output logic                    frame_err
);
   localparam int N  = ROWS * COLS;
   localparam int AW = clog2_min1(N);
   localparam int CW = clog2_min1((ROWS > COLS) ? ROWS : COLS);
   localparam logic [AW-1:0] WLAST = AW'(N - 1);

   bank_st_e              bank_q [2], bank_d [2];
   logic [1:0]            bmode_q [2], bmode_d [2];
   logic                  wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, en_q;
   logic [AW-1:0]         wcnt_q, wcnt_d;
   logic [CW-1:0]         row_q, row_d, col_q, col_d;
   logic [DATA_WIDTH-1:0] odata_q, odata_d;
   logic                  ovalid_q, ovalid_d, olast_q, olast_d, ferr_q, ferr_d;
   logic [DATA_WIDTH-1:0] mem_q [2][N];

   logic          in_rdy, wr_fire, drain_done, load, src, is_last;
   logic [1:0]    src_mode;
   logic [CW-1:0] last_row, last_col;
   logic [AW-1:0] raddr;

   matrix_addr_gen #(.ROWS(ROWS), .COLS(COLS), .AW(AW), .CW(CW)) u_addr (
      .mode_i (src_mode),
      .row_i  (row_q),
      .col_i  (col_q),
      .addr_o (raddr)
   );

   // Once the final beat of a bank sits in the output register, the next load
   // comes from the other bank so back-to-back frames have no bubble.
   always_comb begin
      in_rdy     = en_q && (bank_q[wr_sel_q] == EMPTY || bank_q[wr_sel_q] == FILLING);
      wr_fire    = in_rdy && in_s.tvalid;
      drain_done = ovalid_q && olast_q && out_m.tready;
      src        = (ovalid_q && olast_q) ? ~rd_sel_q : rd_sel_q;
      src_mode   = bmode_q[src];
      load       = (!ovalid_q || out_m.tready) &&
                   (bank_q[src] == FULL || bank_q[src] == DRAINING);
      last_row   = (src_mode == MODE_TRANSPOSE) ? CW'(COLS - 1) : CW'(ROWS - 1);
      last_col   = (src_mode == MODE_TRANSPOSE) ? CW'(ROWS - 1) : CW'(COLS - 1);
      is_last    = (row_q == last_row) && (col_q == last_col);
   end

   always_comb begin
      bank_d   = bank_q;
      bmode_d  = bmode_q;
      wr_sel_d = wr_sel_q;
      rd_sel_d = rd_sel_q;
      wcnt_d   = wcnt_q;
      row_d    = row_q;
      col_d    = col_q;
      odata_d  = odata_q;
      ovalid_d = ovalid_q;
      olast_d  = olast_q;
      ferr_d   = 1'b0;
      if (wr_fire) begin
         ferr_d = (wcnt_q == WLAST) != in_s.tlast;
         if (wcnt_q == '0) bmode_d[wr_sel_q] = mode;
         if (wcnt_q == WLAST) begin
            wcnt_d             = '0;
            bank_d[wr_sel_q]   = FULL;
            wr_sel_d           = ~wr_sel_q;
         end else begin
            wcnt_d             = wcnt_q + 1'b1;
            bank_d[wr_sel_q]   = FILLING;
         end
      end
      if (drain_done) begin
         bank_d[rd_sel_q] = EMPTY;
         rd_sel_d         = ~rd_sel_q;
      end
      if (load) begin
         bank_d[src] = DRAINING;
         odata_d     = mem_q[src][raddr];
         ovalid_d    = 1'b1;
         olast_d     = is_last;
         if (col_q == last_col) begin
            col_d = '0;
            row_d = is_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end else if (out_m.tready) begin
         ovalid_d = 1'b0;
         olast_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q[0]  <= EMPTY;
         bank_q[1]  <= EMPTY;
         bmode_q[0] <= MODE_PASS;
         bmode_q[1] <= MODE_PASS;
         wr_sel_q   <= 1'b0;
         rd_sel_q   <= 1'b0;
         en_q       <= 1'b0;
         wcnt_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         odata_q    <= '0;
         ovalid_q   <= 1'b0;
         olast_q    <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         bank_q     <= bank_d;
         bmode_q    <= bmode_d;
         wr_sel_q   <= wr_sel_d;
         rd_sel_q   <= rd_sel_d;
         en_q       <= 1'b1;
         wcnt_q     <= wcnt_d;
         row_q      <= row_d;
         col_q      <= col_d;
         odata_q    <= odata_d;
         ovalid_q   <= ovalid_d;
         olast_q    <= olast_d;
         ferr_q     <= ferr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem_q[wr_sel_q][wcnt_q] <= in_s.tdata;
   end

   assign in_s.tready  = in_rdy;
   assign out_m.tdata  = odata_q;
   assign out_m.tvalid = ovalid_q;
   assign out_m.tlast  = olast_q;
   assign frame_err    = ferr_q;
endmodule

// File: tb/tb_matrix_reorder_stream.sv
// Directed bench for matrix_reorder_stream: a 4x4 and a 2x3 instance, table of
// frames with hand-computed replay orders, plus stall/framing/reset sequences.
module tb_matrix_reorder_stream;
   localparam int DW = 32;
   typedef struct {
      int         d;
      logic [1:0] mode;
      int         n;
      int         exp [16];
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int chk = 0, errs = 0, cyc = 0, stall_cnt = 0;
   int rd0 = 0, rd1 = 0, ferr0 = 0, ferr1 = 0;
   logic [DW-1:0] qd0 [$], qd1 [$];
   bit ql0 [$], ql1 [$];
   int qc0 [$], qc1 [$];

   logic [DW-1:0] in_data [2];
   logic          in_valid [2], in_last [2], out_rdy [2];
   logic [1:0]    mode_v [2];
   logic          in_rdy [2], o_val [2], o_last [2], ferr [2];
   logic [DW-1:0] o_dat [2];
   vec_t          vecs [8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   matrix_reorder_stream_if #(.DATA_WIDTH(DW)) in4 (), out4 (), in23 (), out23 ();

   assign in4.tdata   = in_data[0];
   assign in4.tvalid  = in_valid[0];
   assign in4.tlast   = in_last[0];
   assign out4.tready = out_rdy[0];
   assign in_rdy[0]   = in4.tready;
   assign o_val[0]    = out4.tvalid;
   assign o_last[0]   = out4.tlast;
   assign o_dat[0]    = out4.tdata;
   assign in23.tdata   = in_data[1];
   assign in23.tvalid  = in_valid[1];
   assign in23.tlast   = in_last[1];
   assign out23.tready = out_rdy[1];
   assign in_rdy[1]    = in23.tready;
   assign o_val[1]     = out23.tvalid;
   assign o_last[1]    = out23.tlast;
   assign o_dat[1]     = out23.tdata;

   matrix_reorder_stream #(.ROWS(4), .COLS(4), .DATA_WIDTH(DW)) dut4 (
      .clk(clk), .rst_n(rst_n), .mode(mode_v[0]),
      .in_s(in4), .out_m(out4), .frame_err(ferr[0]));

   matrix_reorder_stream #(.ROWS(2), .COLS(3), .DATA_WIDTH(DW)) dut23 (
      .clk(clk), .rst_n(rst_n), .mode(mode_v[1]),
      .in_s(in23), .out_m(out23), .frame_err(ferr[1]));

   always @(negedge clk) begin
      if (o_val[0] && out_rdy[0]) begin
         qd0.push_back(o_dat[0]); ql0.push_back(o_last[0]); qc0.push_back(cyc);
      end
      if (o_val[1] && out_rdy[1]) begin
         qd1.push_back(o_dat[1]); ql1.push_back(o_last[1]); qc1.push_back(cyc);
      end
      if (ferr[0]) ferr0 <= ferr0 + 1;
      if (ferr[1]) ferr1 <= ferr1 + 1;
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      chk++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      chk++;
      errs++;
      $display("FAIL %s: timed out", name);
   endtask

   function automatic int avail(input int d);
      return (d == 0) ? qd0.size() - rd0 : qd1.size() - rd1;
   endfunction

   task automatic get_beat(input int d, output logic [DW-1:0] dt, output bit lt, output int c);
      if (d == 0) begin
         dt = qd0[rd0]; lt = ql0[rd0]; c = qc0[rd0]; rd0++;
      end else begin
         dt = qd1[rd1]; lt = ql1[rd1]; c = qc1[rd1]; rd1++;
      end
   endtask

   // Mode is flipped after beat 0 to confirm only the first beat's mode is used.
   task automatic send(input int d, input logic [1:0] m, input logic [DW-1:0] base,
                       input int n, input int extra_last);
      int  g;
      bit  rdy;
      mode_v[d] = m;
      for (int w = 0; w < n; w++) begin
         in_data[d]  = base + DW'(w);
         in_valid[d] = 1'b1;
         in_last[d]  = (w == n - 1) || (w == extra_last);
         g   = 0;
         rdy = 1'b0;
         while (!rdy) begin
            @(negedge clk);
            rdy = in_rdy[d];
            if (!rdy) begin
               stall_cnt++;
               g++;
               if (g > 200) begin
                  timeout("send_in_tready");
                  in_valid[d] = 1'b0;
                  return;
               end
            end
         end
         @(posedge clk); #1;
         if (w == 0) mode_v[d] = ~m;
      end
      in_valid[d] = 1'b0;
      in_last[d]  = 1'b0;
   endtask

   task automatic check_frame(input int d, input logic [DW-1:0] base, input int n,
                              input int exp [16], input string tag,
                              output int c_first, output int c_last);
      int g;
      logic [DW-1:0] dt;
      bit lt;
      int c;
      g = 0; c_first = 0; c_last = 0;
      while (avail(d) < n && g < 300) begin
         @(posedge clk);
         g++;
      end
      if (avail(d) < n) begin
         timeout({tag, "_beats"});
      end else begin
         for (int r = 0; r < n; r++) begin
            get_beat(d, dt, lt, c);
            if (r == 0) c_first = c;
            c_last = c;
            check($sformatf("%s_data%0d", tag, r), dt, base + DW'(exp[r]));
            check($sformatf("%s_last%0d", tag, r), 32'(lt), 32'(r == n - 1));
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int f, c0, c1, c2, c3;
      for (int d = 0; d < 2; d++) begin
         in_data[d] = '0; in_valid[d] = 1'b0; in_last[d] = 1'b0;
         out_rdy[d] = 1'b1; mode_v[d] = 2'd0;
      end
      vecs[0] = '{0, 2'd0, 16, '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15}};
      vecs[1] = '{0, 2'd1, 16, '{15,14,13,12,11,10,9,8,7,6,5,4,3,2,1,0}};
      vecs[2] = '{0, 2'd2, 16, '{0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15}};
      vecs[3] = '{0, 2'd3, 16, '{3,2,1,0,7,6,5,4,11,10,9,8,15,14,13,12}};
      vecs[4] = '{1, 2'd2, 6,  '{0,3,1,4,2,5,0,0,0,0,0,0,0,0,0,0}};
      vecs[5] = '{1, 2'd3, 6,  '{2,1,0,5,4,3,0,0,0,0,0,0,0,0,0,0}};
      vecs[6] = '{1, 2'd1, 6,  '{5,4,3,2,1,0,0,0,0,0,0,0,0,0,0,0}};
      vecs[7] = '{1, 2'd0, 6,  '{0,1,2,3,4,5,0,0,0,0,0,0,0,0,0,0}};

      // Reset values
      #2;
      check("rst_in_tready",  32'(in_rdy[0]), 32'd0);
      check("rst_out_tvalid", 32'(o_val[0]),  32'd0);
      check("rst_out_tlast",  32'(o_last[0]), 32'd0);
      check("rst_out_tdata",  o_dat[0],       32'd0);
      check("rst_frame_err",  32'(ferr[0]),   32'd0);
      check("rst23_in_tready", 32'(in_rdy[1]), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", 32'(in_rdy[0]), 32'd0);
      @(posedge clk); #1;
      check("ready_after_edge",   32'(in_rdy[0]), 32'd1);
      check("ready23_after_edge", 32'(in_rdy[1]), 32'd1);

      // First-frame latency, reverse mode
      send(0, 2'd1, 32'h0, 16, -1);
      check("lat_valid_e0", 32'(o_val[0]), 32'd0);
      @(posedge clk); #1;
      check("lat_valid_e1", 32'(o_val[0]), 32'd1);
      check("lat_data_e1",  o_dat[0], 32'd15);
      check_frame(0, 32'h0, 16, vecs[1].exp, "lat_rev", c0, c1);

      // Table of frames across both shapes and all modes
      for (int k = 0; k < 8; k++) begin
         send(vecs[k].d, vecs[k].mode, DW'(32'h100 * (k + 1)), vecs[k].n, -1);
         check_frame(vecs[k].d, DW'(32'h100 * (k + 1)), vecs[k].n, vecs[k].exp,
                     $sformatf("vec%0d", k), c0, c1);
      end
      check("tbl_ferr4",  32'(ferr0), 32'd0);
      check("tbl_ferr23", 32'(ferr1), 32'd0);

      // Back-to-back frames: no input stall, no output gap
      stall_cnt = 0;
      send(0, 2'd0, 32'h600, 16, -1);
      send(0, 2'd1, 32'h700, 16, -1);
      check("b2b_in_stalls", 32'(stall_cnt), 32'd0);
      check_frame(0, 32'h600, 16, vecs[0].exp, "b2b0", c0, c1);
      check_frame(0, 32'h700, 16, vecs[1].exp, "b2b1", c2, c3);
      check("b2b_span", 32'(c3 - c0), 32'd31);

      // Output stalled: both banks fill, head beat held
      out_rdy[0] = 1'b0;
      send(0, 2'd0, 32'h200, 16, -1);
      send(0, 2'd1, 32'h300, 16, -1);
      @(negedge clk);
      check("stall_in_tready", 32'(in_rdy[0]), 32'd0);
      check("stall_valid",     32'(o_val[0]),  32'd1);
      check("stall_data0",     o_dat[0],       32'h200);
      repeat (5) @(negedge clk);
      check("stall_data_hold",  o_dat[0],       32'h200);
      check("stall_valid_hold", 32'(o_val[0]),  32'd1);
      @(posedge clk); #1;
      out_rdy[0] = 1'b1;
      check_frame(0, 32'h200, 16, vecs[0].exp, "stall0", c0, c1);
      check_frame(0, 32'h300, 16, vecs[1].exp, "stall1", c0, c1);

      // Early tlast on beat 5
      f = ferr0;
      send(0, 2'd0, 32'h400, 16, 5);
      repeat (2) @(posedge clk); #1;
      check("ferr_pulses", 32'(ferr0 - f), 32'd1);
      check_frame(0, 32'h400, 16, vecs[0].exp, "ferr", c0, c1);

      // Asynchronous reset in the middle of a drain
      send(0, 2'd0, 32'h800, 16, -1);
      repeat (4) @(posedge clk);
      #2;
      check("mid_drain_valid", 32'(o_val[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_valid",    32'(o_val[0]),  32'd0);
      check("arst_data",     o_dat[0],       32'd0);
      check("arst_last",     32'(o_last[0]), 32'd0);
      check("arst_in_ready", 32'(in_rdy[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      rd0 = qd0.size();
      send(0, 2'd0, 32'h900, 16, -1);
      check_frame(0, 32'h900, 16, vecs[0].exp, "post_rst", c0, c1);

      $display("Simulation finished: %0d checks, %0d errors", chk, errs);
      $finish;
   end
endmodule
